cam_write_ctrl: RTL and testbench
=================================

# cam_write_ctrl

Sequencing controller for the CAM write port. It accepts insert and invalidate requests and allocates the lowest free entry for each insert. It drives the one-hot CAM write decoder through a registered index/enable/data/valid bundle, and runs a multi-cycle flush that sweeps every entry. It sits between the lookup-table management logic and the CAM array, and keeps the authoritative per-entry valid bitmap and occupancy count.

## Interface
Parameters:
- WIDTH, 32, CAM entry data width
- ADDR_WIDTH, 5, entry index width
- DEPTH, 1<<ADDR_WIDTH, number of entries

Ports:
- clk  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- insert_valid_i  in  1  insert request
- insert_data_i  in  WIDTH  key to store
- insert_ready_o  out  1  insert accepted when valid&ready
- insert_index_o  out  ADDR_WIDTH  entry allocated to the accepted insert; valid in the cycle of acceptance
- inval_valid_i  in  1  invalidate request; always accepted unless flushing
- inval_index_i  in  ADDR_WIDTH  entry to invalidate
- flush_i  in  1  start flush sweep (pulse)
- write_enable_o  out  1  CAM write strobe to decoder
- write_index_o  out  ADDR_WIDTH  CAM write index
- write_data_o  out  WIDTH  CAM write data
- write_valid_o  out  1  valid bit written with the entry
- valid_o  out  DEPTH  per-entry valid bitmap
- count_o  out  ADDR_WIDTH+1  number of valid entries
- full_o / empty_o  out  1 each  count_o==DEPTH / count_o==0
- busy_o  out  1  high while in FLUSH

## Operation
- Two states: IDLE and FLUSH.
- IDLE, priority order: flush_i > inval_valid_i > insert.
- insert_ready_o = IDLE & !full_o & !inval_valid_i & !flush_i. This is combinational from inputs and state.
- Insert accept:
  - Lowest-numbered zero bit of valid_o gives the index, presented on insert_index_o.
  - Next cycle: write_enable_o=1, write_index_o=that index, write_data_o=insert_data_i, write_valid_o=1.
  - Valid bit set and count_o+1, visible the same cycle as the write strobe.
- Invalidate:
  - Next cycle: write_enable_o=1, write_index_o=inval_index_i, write_data_o=0, write_valid_o=0.
  - If the bit was set: clear it and count_o-1. If already clear: the write is still issued and count_o is unchanged.
- Flush:
  - flush_i in IDLE enters FLUSH and resets the sweep counter to 0. A concurrent insert or invalidate that cycle is dropped; it is not accepted.
  - FLUSH: write_enable_o=1 each cycle with index=counter, data=0, valid=0. Counter increments. The corresponding valid bit clears and count_o decrements if it was set.
  - After index DEPTH-1 is written, return to IDLE.
  - flush_i while in FLUSH is ignored. Inserts are stalled (ready=0); invalidates are ignored.
- Arithmetic:
  - count_o is ADDR_WIDTH+1 bits so DEPTH is representable. It never wraps.
  - The sweep counter is ADDR_WIDTH+1 bits internally; terminal detection is at DEPTH-1.
- Reset: valid_o=0, count_o=0, state=IDLE, all write_* outputs 0, busy_o=0. Reset mid-flush aborts the sweep immediately.

## Timing
- All write_* outputs, valid_o and count_o are registered.
- Latency: request accepted in cycle N → CAM write strobe in cycle N+1.
- Sustained throughput: one insert or invalidate per cycle.
- Back-to-back inserts are allocated distinct indices. The finder sees the bitmap with the previous insert's allocation included, because the bit is set at N+1 and the next finder evaluation uses the N+1 bitmap.
- Flush: flush_i in cycle N → busy_o=1 and first write (index 0) in N+1 … last write (index DEPTH-1) in N+DEPTH → IDLE, busy_o=0, insert_ready_o may assert in N+DEPTH+1.
- full_o, empty_o and busy_o are decoded from registered state; no combinational path from inputs.
- Only insert_ready_o and insert_index_o are combinational from inputs.

## Structure
- Shared package cam_pkg holds:
  - typedef enum logic {IDLE, FLUSH} cam_ctrl_state_t
  - shared width constants used by the CAM and its decoder
- Sub-module cam_free_finder: parameterised lowest-zero priority encoder over DEPTH bits. Outputs index and an any_free flag.
- The controller instantiates one finder.

## Test plan
- After reset, 3 inserts back-to-back (0xA, 0xB, 0xC) → writes to indices 0,1,2 in consecutive cycles, valid=1; count_o=3, valid_o=0b111.
- Fill all 32 entries, then assert insert_valid_i → insert_ready_o=0, full_o=1. Invalidate index 7, then insert 0xD → written at index 7.
- Same cycle: insert_valid_i=1 and inval_valid_i=1 with index 2 → invalidate write to index 2 issued, insert not accepted. Insert is accepted next cycle at index 2.
- Invalidate an already-empty index 5 → write strobe to 5 with valid=0; count_o unchanged.
- With 4 valid entries, pulse flush_i → busy_o high for exactly 32 cycles, writes to indices 0..31 in order, count_o=0, empty_o=1, then ready returns.
- Assert reset at sweep index 10 → next cycle state IDLE, busy_o=0, write_enable_o=0, valid_o=0, count_o=0.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared CAM definitions: controller state encoding and the widths used by the
// CAM array, its write decoder and the write-port controller.
package cam_pkg;

    localparam int CAM_WIDTH      = 32;
    localparam int CAM_ADDR_WIDTH = 5;
    localparam int CAM_DEPTH      = 1 << CAM_ADDR_WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } cam_ctrl_state_t;

endpackage

// File: rtl/cam_write_ctrl_if.sv
// Request/response and CAM write-port bundle of the CAM write controller.
// The master is the table-management side; the slave is the controller.
interface cam_write_ctrl_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  insert_valid_i;
    logic [WIDTH-1:0]      insert_data_i;
    logic                  insert_ready_o;
    logic [ADDR_WIDTH-1:0] insert_index_o;
    logic                  inval_valid_i;
    logic [ADDR_WIDTH-1:0] inval_index_i;
    logic                  write_enable_o;
    logic [ADDR_WIDTH-1:0] write_index_o;
    logic [WIDTH-1:0]      write_data_o;
    logic                  write_valid_o;

    modport master (
        output insert_valid_i, insert_data_i, inval_valid_i, inval_index_i,
        input  insert_ready_o, insert_index_o,
        input  write_enable_o, write_index_o, write_data_o, write_valid_o
    );

    modport slave (
        input  insert_valid_i, insert_data_i, inval_valid_i, inval_index_i,
        output insert_ready_o, insert_index_o,
        output write_enable_o, write_index_o, write_data_o, write_valid_o
    );
endinterface

// File: rtl/cam_free_finder.sv
// Lowest-zero priority encoder over the entry valid bitmap.
module cam_free_finder #(
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic [DEPTH-1:0]      used_i,
    output logic [ADDR_WIDTH-1:0] idx_o,
    output logic                  any_free_o
);

    // Scan downward so the last hit is the lowest free entry.
    always_comb begin
        idx_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!used_i[i]) idx_o = ADDR_WIDTH'(i);
        end
    end

    assign any_free_o = ~&used_i;

endmodule

// File: rtl/cam_write_ctrl.sv
// CAM write-port sequencer: allocates free entries for inserts, issues
// invalidates, sweeps all entries on flush, and owns the valid bitmap/count.
module cam_write_ctrl
    import cam_pkg::*;
#(
    parameter int WIDTH      = CAM_WIDTH,
    parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    cam_write_ctrl_if.slave       bus,
    input  logic                  flush_i,
    output logic [DEPTH-1:0]      valid_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  busy_o
);

    localparam logic ST_IDLE  = IDLE;
    localparam logic ST_FLUSH = FLUSH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);

    logic                  state_q,  state_d;
    logic [ADDR_WIDTH:0]   sweep_q,  sweep_d;
    logic [DEPTH-1:0]      valid_q,  valid_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic                  we_q,     we_d;
    logic [ADDR_WIDTH-1:0] widx_q,   widx_d;
    logic [WIDTH-1:0]      wdata_q,  wdata_d;
    logic                  wvalid_q, wvalid_d;

    logic [ADDR_WIDTH-1:0] free_idx;
    logic                  any_free;
    logic                  ins_ready;
    logic [ADDR_WIDTH-1:0] sweep_idx;

    cam_free_finder #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_finder (
        .used_i     (valid_q),
        .idx_o      (free_idx),
        .any_free_o (any_free)
    );

    assign full_o    = (count_q == DEPTH_C);
    assign empty_o   = (count_q == '0);
    assign busy_o    = (state_q == ST_FLUSH);
    assign valid_o   = valid_q;
    assign count_o   = count_q;
    assign sweep_idx = sweep_q[ADDR_WIDTH-1:0];

    assign ins_ready = (state_q == ST_IDLE) & !full_o & any_free
                     & !bus.inval_valid_i & !flush_i;

    assign bus.insert_ready_o = ins_ready;
    assign bus.insert_index_o = free_idx;
    assign bus.write_enable_o = we_q;
    assign bus.write_index_o  = widx_q;
    assign bus.write_data_o   = wdata_q;
    assign bus.write_valid_o  = wvalid_q;

    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        valid_d  = valid_q;
        count_d  = count_q;
        we_d     = 1'b0;
        widx_d   = '0;
        wdata_d  = '0;
        wvalid_d = 1'b0;

        if (state_q == ST_IDLE) begin
            if (flush_i) begin
                // Entry 0 is written on the way in so the sweep's first strobe
                // lines up with the first busy cycle.
                state_d = ST_FLUSH;
                sweep_d = ONE_C;
                we_d    = 1'b1;
                if (valid_q[0]) begin
                    valid_d[0] = 1'b0;
                    count_d    = count_q - ONE_C;
                end
            end else if (bus.inval_valid_i) begin
                we_d   = 1'b1;
                widx_d = bus.inval_index_i;
                if (valid_q[bus.inval_index_i]) begin
                    valid_d[bus.inval_index_i] = 1'b0;
                    count_d = count_q - ONE_C;
                end
            end else if (bus.insert_valid_i && ins_ready) begin
                we_d              = 1'b1;
                widx_d            = free_idx;
                wdata_d           = bus.insert_data_i;
                wvalid_d          = 1'b1;
                valid_d[free_idx] = 1'b1;
                count_d           = count_q + ONE_C;
            end
        end else begin
            // sweep_q reaching DEPTH means the strobe for DEPTH-1 is on the
            // port this cycle; drop back to IDLE behind it.
            if (sweep_q == DEPTH_C) begin
                state_d = ST_IDLE;
                sweep_d = '0;
            end else begin
                we_d    = 1'b1;
                widx_d  = sweep_idx;
                sweep_d = sweep_q + ONE_C;
                if (valid_q[sweep_idx]) begin
                    valid_d[sweep_idx] = 1'b0;
                    count_d = count_q - ONE_C;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sweep_q  <= '0;
            valid_q  <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            widx_q   <= '0;
            wdata_q  <= '0;
            wvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            we_q     <= we_d;
            widx_q   <= widx_d;
            wdata_q  <= wdata_d;
            wvalid_q <= wvalid_d;
        end
    end

endmodule

// File: tb/tb_cam_write_ctrl.sv
// Scoreboard bench for cam_write_ctrl: expected CAM writes are queued at issue
// time and checked by a separate monitor whenever the write strobe is seen.
module tb_cam_write_ctrl;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int D  = 1 << AW;

    typedef struct {
        logic [AW-1:0] idx;
        logic [W-1:0]  data;
        logic          vld;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush_i = 1'b0;
    logic [D-1:0]  valid_o;
    logic [AW:0]   count_o;
    logic          full_o, empty_o, busy_o;

    int n_cmp = 0;
    int n_err = 0;
    wr_t sb[$];

    cam_write_ctrl_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

    cam_write_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .flush_i (flush_i),
        .valid_o (valid_o),
        .count_o (count_o),
        .full_o  (full_o),
        .empty_o (empty_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic [W-1:0] data, input logic vld);
        wr_t e;
        e.idx  = AW'(idx);
        e.data = data;
        e.vld  = vld;
        sb.push_back(e);
    endtask

    // Issue one insert this cycle, expecting it to be accepted at exp_idx.
    task automatic do_insert(input logic [W-1:0] data, input int exp_idx);
        bus.insert_valid_i = 1'b1;
        bus.insert_data_i  = data;
        #1;
        chk("insert_ready", 64'(bus.insert_ready_o), 64'd1);
        chk("insert_index", 64'(bus.insert_index_o), 64'(exp_idx));
        push(exp_idx, data, 1'b1);
        step();
    endtask

    task automatic do_inval(input int idx);
        bus.inval_valid_i = 1'b1;
        bus.inval_index_i = AW'(idx);
        push(idx, '0, 1'b0);
        step();
        bus.inval_valid_i = 1'b0;
    endtask

    // Pulse flush; optionally poke ignored requests mid-sweep. Returns busy length.
    task automatic do_flush(input bit poke, output int busy_cnt);
        for (int i = 0; i < D; i++) push(i, '0, 1'b0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        busy_cnt = 0;
        while (busy_o && busy_cnt < 64) begin
            busy_cnt++;
            if (poke && busy_cnt == 5) begin
                flush_i            = 1'b1;
                bus.insert_valid_i = 1'b1;
                bus.insert_data_i  = 32'hDEAD;
                bus.inval_valid_i  = 1'b1;
                bus.inval_index_i  = AW'(20);
                #1;
                chk("ready_in_flush", 64'(bus.insert_ready_o), 64'd0);
            end else begin
                flush_i            = 1'b0;
                bus.insert_valid_i = 1'b0;
                bus.inval_valid_i  = 1'b0;
            end
            step();
        end
        flush_i            = 1'b0;
        bus.insert_valid_i = 1'b0;
        bus.inval_valid_i  = 1'b0;
    endtask

    // Monitor: every observed CAM write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.write_enable_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got idx %0d data %0h vld %0b expected none",
                         bus.write_index_o, bus.write_data_o, bus.write_valid_o);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_index", 64'(bus.write_index_o), 64'(e.idx));
                chk("wr_data",  64'(bus.write_data_o),  64'(e.data));
                chk("wr_valid", 64'(bus.write_valid_o), 64'(e.vld));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bc;
        bus.insert_valid_i = 1'b0;
        bus.insert_data_i  = '0;
        bus.inval_valid_i  = 1'b0;
        bus.inval_index_i  = '0;
        repeat (3) step();
        reset = 1'b0;

        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_full",  64'(full_o),  64'd0);
        chk("rst_busy",  64'(busy_o),  64'd0);
        chk("rst_we",    64'(bus.write_enable_o), 64'd0);

        // Back-to-back inserts get consecutive lowest-free indices.
        do_insert(32'hA, 0);
        do_insert(32'hB, 1);
        do_insert(32'hC, 2);
        bus.insert_valid_i = 1'b0;
        chk("count_3", 64'(count_o), 64'd3);
        chk("valid_3", 64'(valid_o), 64'h7);

        for (int i = 0; i < D - 3; i++) do_insert(32'h100 + 32'(i), 3 + i);
        bus.insert_valid_i = 1'b1;
        #1;
        chk("full_ready", 64'(bus.insert_ready_o), 64'd0);
        chk("full_flag",  64'(full_o), 64'd1);
        chk("full_count", 64'(count_o), 64'd32);
        bus.insert_valid_i = 1'b0;

        do_inval(7);
        chk("inval7_count", 64'(count_o), 64'd31);
        chk("inval7_bit",   64'(valid_o[7]), 64'd0);
        do_insert(32'hD, 7);
        bus.insert_valid_i = 1'b0;
        chk("refill_count", 64'(count_o), 64'd32);

        // Invalidate beats a concurrent insert; insert lands next cycle.
        bus.insert_valid_i = 1'b1;
        bus.insert_data_i  = 32'hE;
        bus.inval_valid_i  = 1'b1;
        bus.inval_index_i  = AW'(2);
        #1;
        chk("conflict_ready", 64'(bus.insert_ready_o), 64'd0);
        push(2, '0, 1'b0);
        step();
        bus.inval_valid_i = 1'b0;
        do_insert(32'hE, 2);
        bus.insert_valid_i = 1'b0;
        chk("conflict_count", 64'(count_o), 64'd32);

        do_inval(5);
        chk("inval5_count", 64'(count_o), 64'd31);
        do_inval(5);
        chk("inval5_again_count", 64'(count_o), 64'd31);

        do_flush(1'b1, bc);
        chk("flush1_busy_len", 64'(bc), 64'd32);
        chk("flush1_count", 64'(count_o), 64'd0);
        chk("flush1_valid", 64'(valid_o), 64'd0);

        do_insert(32'h11, 0);
        do_insert(32'h22, 1);
        do_insert(32'h33, 2);
        do_insert(32'h44, 3);
        bus.insert_valid_i = 1'b0;
        chk("pre_flush_count", 64'(count_o), 64'd4);

        // Insert issued alongside flush is dropped.
        bus.insert_valid_i = 1'b1;
        bus.insert_data_i  = 32'h55;
        #1;
        chk("flush_insert_ready", 64'(bus.insert_ready_o), 64'd1);
        flush_i = 1'b1;
        #1;
        chk("flush_drop_ready", 64'(bus.insert_ready_o), 64'd0);
        flush_i = 1'b0;
        bus.insert_valid_i = 1'b0;
        do_flush(1'b0, bc);
        chk("flush2_busy_len", 64'(bc), 64'd32);
        chk("flush2_count", 64'(count_o), 64'd0);
        chk("flush2_empty", 64'(empty_o), 64'd1);
        chk("flush2_ready", 64'(bus.insert_ready_o), 64'd1);

        // Reset in the middle of a sweep.
        do_insert(32'h66, 0);
        do_insert(32'h77, 1);
        bus.insert_valid_i = 1'b0;
        for (int i = 0; i <= 10; i++) push(i, '0, 1'b0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        repeat (10) step();
        chk("mid_sweep_idx",  64'(bus.write_index_o), 64'd10);
        chk("mid_sweep_busy", 64'(busy_o), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("abort_busy",  64'(busy_o), 64'd0);
        chk("abort_we",    64'(bus.write_enable_o), 64'd0);
        chk("abort_valid", 64'(valid_o), 64'd0);
        chk("abort_count", 64'(count_o), 64'd0);
        reset = 1'b0;
        repeat (3) step();
        chk("abort_no_writes", 64'(bus.write_enable_o), 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
